// File: rtl/dut_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dut_stream_sequencer
// Desc     : Frames MM2S samples into a free-running DUT, realigns its output by
//            DUT_LATENCY and returns framed results to S2MM.
//            Optional test-vector stream: DUT_STREAM_SEQ_TESTVEC_EN
// Revision : 1.0
// ============================================================================
module dut_stream_sequencer #(
  parameter int DW_IN       = 16,
  parameter int DW_OUT      = 16,
  parameter int DUT_LATENCY = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [CNT_W-1:0]  cfg_frame_len,
  input  logic [CNT_W-1:0]  cfg_num_frames,
  output logic              busy,
  output logic              done,
  input  logic [31:0]       src_tdata,
  input  logic              src_tvalid,
  output logic              src_tready,
  output logic [DW_IN-1:0]  dut_din,
  output logic              dut_din_vld,
  input  logic [DW_OUT-1:0] dut_dout,
`ifdef DUT_STREAM_SEQ_TESTVEC_EN
  output logic [63:0]       tv_tdata,
  output logic [7:0]        tv_tkeep,
  output logic              tv_tvalid,
  output logic              tv_tlast,
  input  logic              tv_tready,
`endif
  output logic [31:0]       snk_tdata,
  output logic [3:0]        snk_tkeep,
  output logic              snk_tvalid,
  output logic              snk_tlast,
  input  logic              snk_tready
);

  localparam int c_aw = $clog2(FIFO_DEPTH);
`ifdef DUT_STREAM_SEQ_TESTVEC_EN
  localparam int c_fifo_w = DW_OUT + DW_IN;
`else
  localparam int c_fifo_w = DW_OUT;
`endif
  localparam logic [c_aw:0]      c_depth   = {1'b1, {c_aw{1'b0}}};
  localparam logic [c_aw:0]      c_ptr_one = {{c_aw{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   c_one     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [2*CNT_W-1:0] c_one_w   = {{(2*CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_done;
  logic [CNT_W-1:0]     r_frame_len;
  logic [CNT_W-1:0]     r_out_cnt;
  logic [2*CNT_W-1:0]   r_total;
  logic [2*CNT_W-1:0]   r_accepted;
  logic [2*CNT_W-1:0]   r_popped;
  logic [c_aw:0]        r_occ;
  logic [DW_IN-1:0]     r_din;
  logic                 r_din_vld;
  logic [DUT_LATENCY-1:0] r_vld_dly;
  logic [c_fifo_w-1:0]  r_mem [FIFO_DEPTH];
  logic [c_aw:0]        r_wr_ptr;
  logic [c_aw:0]        r_rd_ptr;

  logic                 w_start_ok;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_fifo_vld;
  logic [2*CNT_W-1:0]   w_acc_next;
  logic [2*CNT_W-1:0]   w_pop_next;
  logic [c_fifo_w-1:0]  w_wdata;
  logic [c_fifo_w-1:0]  w_rd;
  logic [DW_OUT-1:0]    w_dout;
  logic                 w_src_unused;

  assign w_src_unused = ^src_tdata[31:DW_IN];

  assign w_start_ok = (r_state == S_IDLE) && cfg_start &&
                      (cfg_frame_len != '0) && (cfg_num_frames != '0);
  // occ counts in-flight samples (delay line + FIFO), so the FIFO cannot overflow
  assign src_tready = (r_state == S_RUN) && (r_accepted < r_total) && (r_occ < c_depth);
  assign w_accept   = src_tvalid && src_tready;
  assign w_fifo_vld = (r_wr_ptr != r_rd_ptr);
`ifdef DUT_STREAM_SEQ_TESTVEC_EN
  assign w_pop      = w_fifo_vld && snk_tready && tv_tready;
`else
  assign w_pop      = w_fifo_vld && snk_tready;
`endif
  assign w_push     = r_vld_dly[DUT_LATENCY-1];
  assign w_acc_next = r_accepted + c_one_w;
  assign w_pop_next = r_popped + c_one_w;

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign dut_din     = r_din;
  assign dut_din_vld = r_din_vld;

`ifdef DUT_STREAM_SEQ_TESTVEC_EN
  logic [31:0]          r_out_idx;
  logic [DW_IN-1:0]     r_din_dly [DUT_LATENCY];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_done      <= 1'b0;
      r_frame_len <= '0;
      r_total     <= '0;
      r_accepted  <= '0;
      r_popped    <= '0;
      r_out_cnt   <= '0;
      r_occ       <= '0;
`ifdef DUT_STREAM_SEQ_TESTVEC_EN
      r_out_idx   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_state     <= S_RUN;
            r_frame_len <= cfg_frame_len;
            r_total     <= {{CNT_W{1'b0}}, cfg_frame_len} * {{CNT_W{1'b0}}, cfg_num_frames};
            r_done      <= 1'b0;
          end else if (cfg_start) begin
            r_done      <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_accept && (w_acc_next == r_total))
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_pop && (w_pop_next == r_total)) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_start_ok) begin
        r_accepted <= '0;
        r_popped   <= '0;
        r_out_cnt  <= '0;
`ifdef DUT_STREAM_SEQ_TESTVEC_EN
        r_out_idx  <= '0;
`endif
      end else begin
        if (w_accept)
          r_accepted <= w_acc_next;
        if (w_pop) begin
          r_popped  <= w_pop_next;
          r_out_cnt <= (r_out_cnt == r_frame_len - c_one) ? '0 : r_out_cnt + c_one;
`ifdef DUT_STREAM_SEQ_TESTVEC_EN
          r_out_idx <= r_out_idx + 32'd1;
`endif
        end
      end

      case ({w_accept, w_pop})
        2'b10:   r_occ <= r_occ + c_ptr_one;
        2'b01:   r_occ <= r_occ - c_ptr_one;
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_din     <= '0;
      r_din_vld <= 1'b0;
      r_vld_dly <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
    end else begin
      r_din_vld <= w_accept;
      if (w_accept)
        r_din <= src_tdata[DW_IN-1:0];
      r_vld_dly[0] <= r_din_vld;
      for (int k = 1; k < DUT_LATENCY; k++)
        r_vld_dly[k] <= r_vld_dly[k-1];
      if (w_push)
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
    end
  end

`ifdef DUT_STREAM_SEQ_TESTVEC_EN
  // din travels alongside its valid so each FIFO entry pairs din with its dout
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DUT_LATENCY; k++)
        r_din_dly[k] <= '0;
    end else begin
      r_din_dly[0] <= r_din;
      for (int k = 1; k < DUT_LATENCY; k++)
        r_din_dly[k] <= r_din_dly[k-1];
    end
  end
  assign w_wdata = {r_din_dly[DUT_LATENCY-1], dut_dout};
`else
  assign w_wdata = dut_dout;
`endif

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr[c_aw-1:0]] <= w_wdata;
  end

  assign w_rd   = r_mem[r_rd_ptr[c_aw-1:0]];
  assign w_dout = w_rd[DW_OUT-1:0];

  assign snk_tvalid = w_fifo_vld;
  assign snk_tdata  = w_fifo_vld ? 32'($signed(w_dout)) : 32'd0;
  assign snk_tkeep  = w_fifo_vld ? 4'hF : 4'h0;
  assign snk_tlast  = w_fifo_vld && (r_out_cnt == r_frame_len - c_one);

`ifdef DUT_STREAM_SEQ_TESTVEC_EN
  logic [DW_IN-1:0] w_tv_din;
  assign w_tv_din  = w_rd[c_fifo_w-1:DW_OUT];
  assign tv_tvalid = w_fifo_vld;
  assign tv_tlast  = snk_tlast;
  assign tv_tkeep  = w_fifo_vld ? 8'hFF : 8'h00;
  assign tv_tdata  = w_fifo_vld ?
                     {r_out_idx, 16'($signed(w_tv_din)), 16'($signed(w_dout))} : 64'd0;
`endif

endmodule
`default_nettype wire
